// File: rtl/aes_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : aes_stream_scheduler
// Brief   : Round-robin sharing of one fixed-latency AES core between an
//           encrypt and a decrypt AXI-Stream, with credit-guarded output FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
module aes_stream_scheduler #(
    parameter int DATA_WIDTH  = 128,
    parameter int AES_LATENCY = 21,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  key_ready,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    input  logic                  s00_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                  s01_axis_tvalid,
    output logic                  s01_axis_tready,
    input  logic                  s01_axis_tlast,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic                  m00_axis_tlast,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic                  m01_axis_tvalid,
    input  logic                  m01_axis_tready,
    output logic                  m01_axis_tlast,
    output logic                  core_in_valid,
    output logic [DATA_WIDTH-1:0] core_in_data,
    output logic                  core_in_decrypt,
    input  logic                  core_out_valid,
    input  logic [DATA_WIDTH-1:0] core_out_data,
    output logic                  busy,
    output logic                  err_sticky
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_INF_W = $clog2(AES_LATENCY + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_SUM_W = ((c_CNT_W > c_INF_W) ? c_CNT_W : c_INF_W) + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(FIFO_DEPTH);

    typedef struct packed {
        logic valid;
        logic chan;
        logic last;
    } tag_t;

    logic                  r_run;
    logic                  r_rr;
    logic                  r_err;
    tag_t                  r_tag [AES_LATENCY];

    logic [1:0]            w_tvalid, w_tlast, w_req, w_elig, w_tready, w_issue;
    logic [1:0]            w_push, w_ovf, w_busy_ch, w_m_tvalid, w_m_tlast, w_m_tready;
    logic [DATA_WIDTH-1:0] w_tdata   [2];
    logic [DATA_WIDTH-1:0] w_m_tdata [2];
    logic                  w_gnt_vld, w_gnt;
    tag_t                  w_tag_out;
    logic                  w_tag_ok;

    assign w_tvalid   = {s01_axis_tvalid, s00_axis_tvalid};
    assign w_tlast    = {s01_axis_tlast,  s00_axis_tlast};
    assign w_tdata[0] = s00_axis_tdata;
    assign w_tdata[1] = s01_axis_tdata;
    assign w_m_tready = {m01_axis_tready, m00_axis_tready};

    // r_run holds issue off until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    always_comb begin
        w_req     = w_tvalid & w_elig;
        w_gnt_vld = |w_req;
        w_gnt     = (w_req == 2'b11) ? r_rr : w_req[1];
        w_tready[0] = w_elig[0] && ((w_gnt_vld && !w_gnt) || !w_req[1]);
        w_tready[1] = w_elig[1] && ((w_gnt_vld &&  w_gnt) || !w_req[0]);
        w_issue = 2'b00;
        if (w_gnt_vld) w_issue[w_gnt] = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)       r_rr <= 1'b0;
        else if (w_gnt_vld) r_rr <= !w_gnt;
    end

    // Tag pipe mirrors the core latency; its tail lines up with core_out_valid.
    assign w_tag_out = r_tag[AES_LATENCY-1];
    assign w_tag_ok  = core_out_valid && w_tag_out.valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < AES_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= {w_gnt_vld, w_gnt_vld && w_gnt, w_gnt_vld && w_tlast[w_gnt]};
            for (int i = 1; i < AES_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    generate
        for (genvar c = 0; c < 2; c++) begin : g_ch
            logic [c_INF_W-1:0]  r_inflight;
            logic [c_CNT_W-1:0]  r_count;
            logic [c_PTR_W-1:0]  r_wptr, r_rptr;
            logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
            logic                w_ret, w_pop, w_full;
            logic [c_SUM_W-1:0]  w_used;

            assign w_ret     = w_tag_ok && (w_tag_out.chan == 1'(c));
            assign w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
            assign w_push[c] = w_ret && !w_full;
            assign w_ovf[c]  = w_ret && w_full;
            assign w_pop     = w_m_tready[c] && (r_count != '0);
            // Credits: FIFO occupancy plus beats still inside the core.
            assign w_used    = c_SUM_W'(r_count) + c_SUM_W'(r_inflight);
            assign w_elig[c] = r_run && key_ready && (w_used < c_DEPTH);

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_inflight <= '0;
                    r_count    <= '0;
                    r_wptr     <= '0;
                    r_rptr     <= '0;
                end else begin
                    if (w_issue[c] && !w_ret)      r_inflight <= r_inflight + c_INF_W'(1);
                    else if (!w_issue[c] && w_ret) r_inflight <= r_inflight - c_INF_W'(1);
                    if (w_push[c]) r_wptr <= r_wptr + c_PTR_W'(1);
                    if (w_pop)     r_rptr <= r_rptr + c_PTR_W'(1);
                    if (w_push[c] && !w_pop)      r_count <= r_count + c_CNT_W'(1);
                    else if (w_pop && !w_push[c]) r_count <= r_count - c_CNT_W'(1);
                end
            end

            always_ff @(posedge aclk) begin
                if (w_push[c]) r_mem[r_wptr] <= {w_tag_out.last, core_out_data};
            end

            assign w_m_tvalid[c] = (r_count != '0);
            assign w_m_tdata[c]  = w_m_tvalid[c] ? r_mem[r_rptr][DATA_WIDTH-1:0] : '0;
            assign w_m_tlast[c]  = w_m_tvalid[c] && r_mem[r_rptr][DATA_WIDTH];
            assign w_busy_ch[c]  = (r_count != '0) || (r_inflight != '0);
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_err <= 1'b0;
        else          r_err <= r_err || (core_out_valid != w_tag_out.valid) || (|w_ovf);
    end

    assign s00_axis_tready = w_tready[0];
    assign s01_axis_tready = w_tready[1];
    assign core_in_valid   = w_gnt_vld;
    assign core_in_data    = w_gnt_vld ? w_tdata[w_gnt] : '0;
    assign core_in_decrypt = w_gnt_vld && w_gnt;
    assign m00_axis_tdata  = w_m_tdata[0];
    assign m00_axis_tvalid = w_m_tvalid[0];
    assign m00_axis_tlast  = w_m_tlast[0];
    assign m01_axis_tdata  = w_m_tdata[1];
    assign m01_axis_tvalid = w_m_tvalid[1];
    assign m01_axis_tlast  = w_m_tlast[1];
    assign busy            = |w_busy_ch;
    assign err_sticky      = r_err;

endmodule
`default_nettype wire

// File: doc/aes_stream_scheduler.md
Name: aes_stream_scheduler

Overview:
- Shares one fixed-latency, non-stallable AES core between two AXI-Stream requesters: s00 (encrypt) and s01 (decrypt).
- Arbitrates input beats round-robin and tags each issued beat with its channel and tlast.
- Routes results into per-channel output FIFOs that drive m00/m01.
- Credit accounting guarantees downstream backpressure never drops or corrupts data in flight.
- Sits between the AXI-Stream ports of axi_aes_ip and its AES round pipeline.

Parameters:
- DATA_WIDTH, 128, stream and core data width.
- AES_LATENCY, 21, cycles from core_in_valid to matching core_out_valid.
- FIFO_DEPTH, 32, entries per output FIFO; power of two, must be >= AES_LATENCY+1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- key_ready  in  1  key expansion complete; issue allowed only while high
- s00_axis_tdata  in  DATA_WIDTH  encrypt plaintext
- s00_axis_tvalid  in  1  encrypt input valid
- s00_axis_tready  out  1  encrypt input ready
- s00_axis_tlast  in  1  encrypt packet end
- s01_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  decrypt input, same rules as s00
- m00_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  ciphertext output
- m01_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  plaintext output
- core_in_valid  out  1  issue strobe to AES core
- core_in_data  out  DATA_WIDTH  block issued to core
- core_in_decrypt  out  1  0 = encrypt, 1 = decrypt
- core_out_valid  in  1  core result strobe
- core_out_data  in  DATA_WIDTH  core result
- busy  out  1  any beat in flight or any FIFO non-empty
- err_sticky  out  1  protocol/tag error latched; cleared only by reset

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFOs empty, inflight counters 0, tag pipe cleared, rr pointer = s00. In-flight beats are discarded; any core_out_valid that arrives after reset with an empty tag slot sets err_sticky.
- Eligibility: elig[c] = key_ready && (fifo_count[c] + inflight[c] < FIFO_DEPTH).
- Grant (combinational): if exactly one channel has tvalid && elig, grant it. If both do, grant the rr pointer. On each issue the rr pointer moves to the other channel. Only the granted channel sees tready=1.
- tready[c] = elig[c] && (c is granted or the other channel is not requesting). tready may depend on the other channel's tvalid.
- Issue: on handshake, in the same cycle, core_in_valid=1, core_in_data=tdata, core_in_decrypt=channel. At most one issue per cycle.
- Tag pipe: an AES_LATENCY-deep shift register of {valid, chan, last} that shifts every cycle (the core never stalls).
- Return: on core_out_valid, require tag_out.valid=1; otherwise set err_sticky and drop the data. Likewise, tag_out.valid=1 with core_out_valid=0 sets err_sticky. A valid result is pushed into FIFO[tag.chan] together with tag.last.
- inflight[c]: +1 on issue, -1 on return. Issue and return in the same cycle for the same channel leave it unchanged. Width is clog2(AES_LATENCY+1).
- FIFOs: registered outputs. m_tvalid asserts the cycle after the push. Push and pop in the same cycle leave the count unchanged. A push into a full FIFO (unreachable given credits) sets err_sticky and drops the data. tdata and tlast must hold stable while tvalid=1 && tready=0.
- Latency: first result appears on m tvalid AES_LATENCY+1 cycles after the input handshake edge. Sustained throughput is 1 beat/cycle aggregate.
- key_ready falling: issue stops immediately; beats already in flight drain normally.
- busy = |inflight | any FIFO non-empty.

Test Plan:
- Single encrypt beat: key_ready=1, send 128'h00112233445566778899aabbccddeeff with tlast=1 on s00 at cycle T. Expect core_in_valid=1 and core_in_decrypt=0 at T. The core model returns AES-128 (key 000102..0f) result 69c4e0d86a7b0430d8cdb78070b4c55a. Expect m00 tvalid=1 with that value and tlast=1 at T+22; m01 stays idle.
- Stall: stream 40 beats on s00 with m00_tready=0. Expect s00_tready to drop after exactly 32 accepted beats, no err_sticky, no m00 tvalid glitch. Release m00_tready: all 40 beats emerge in order, tlast only on beat 40.
- Contention: s00 and s01 both valid continuously for 10 beats each. Expect strictly alternating issue s00, s01, s00, ..., each output stream in order, 20 core issues in 20 cycles.
- Asymmetric backpressure: m01_tready=0, m00_tready=1. The s01 path fills to 32 and stalls while s00 continues at full rate, unaffected.
- key_ready low mid-stream: drop key_ready after 5 issues. Expect s00_tready=0 next cycle, the 5 results still delivered, busy falls to 0 after drain.
- Reset mid-flight: assert aresetn=0 with 10 beats in flight. Expect all outputs 0 immediately. The model's stale returns after release set err_sticky=1; a subsequent clean reset clears it.
